// File: rtl/hex_display_scanner.sv
// hex_display_scanner: multi-digit hexadecimal 7-segment driver.
// A value captured on load is decoded one nibble per clock (MSD first) through
// a single shared decoder into a shadow register. All digits are committed to
// the output register together, so a partially scanned value is never visible.
// Optional feature macro: HEX_BLINK_EN (adds blink input and blink divider).
module hex_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int LZ_BLANK   = 1,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
`ifdef HEX_BLINK_EN
  input  logic                    blink,
`endif
  output logic [7*NUM_DIGITS-1:0] HEX,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int HEX_W = 7 * NUM_DIGITS;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] cap_q;
  logic [HEX_W-1:0]        shadow_q;
  logic [HEX_W-1:0]        hex_store_q, hex_store_d;
  logic [IDX_W-1:0]        idx_q;
  logic                    nz_q;
  logic                    done_q;

  logic                    last_digit;
  logic [3:0]              nib;
  logic                    blank_digit;
  logic [6:0]              seg;
  logic                    accept;

  // Active-low hex decode, bit6 = g ... bit0 = a.
  function automatic logic [6:0] decode_nibble(input logic [3:0] n);
    case (n)
      4'h0: decode_nibble = 7'b1000000;
      4'h1: decode_nibble = 7'b1111001;
      4'h2: decode_nibble = 7'b0100100;
      4'h3: decode_nibble = 7'b0110000;
      4'h4: decode_nibble = 7'b0011001;
      4'h5: decode_nibble = 7'b0010010;
      4'h6: decode_nibble = 7'b0000010;
      4'h7: decode_nibble = 7'b1111000;
      4'h8: decode_nibble = 7'b0000000;
      4'h9: decode_nibble = 7'b0010000;
      4'hA: decode_nibble = 7'b0001000;
      4'hB: decode_nibble = 7'b0000011;
      4'hC: decode_nibble = 7'b1000110;
      4'hD: decode_nibble = 7'b0100001;
      4'hE: decode_nibble = 7'b0000110;
      default: decode_nibble = 7'b0001110;
    endcase
  endfunction

  assign last_digit = (idx_q == '0);
  assign accept     = (state_q == ST_IDLE) && load;

  // Shared decoder: current nibble, leading-zero decision and segment pattern.
  always_comb begin
    nib         = cap_q[4*int'(idx_q) +: 4];
    blank_digit = (LZ_BLANK != 0) && (nib == 4'd0) && !nz_q && !last_digit;
    seg         = blank_digit ? SEG_BLANK : decode_nibble(nib);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic: load only starts a scan from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load)       state_d = ST_SCAN;
      ST_SCAN: if (last_digit) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == ST_SCAN);
    done = done_q;
  end

  // Stored display value: digit 0 is merged straight from the decoder on the final edge.
  always_comb begin
    hex_store_d = hex_store_q;
    if ((state_q == ST_SCAN) && last_digit) begin
      hex_store_d      = shadow_q;
      hex_store_d[6:0] = seg;
    end
  end

  // Scan datapath: capture, per-digit decode into shadow, final commit and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q       <= '0;
      shadow_q    <= '1;
      hex_store_q <= '1;
      idx_q       <= '0;
      nz_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= (state_q == ST_SCAN) && last_digit;
      hex_store_q <= hex_store_d;
      if (accept) begin
        cap_q <= value;
        idx_q <= IDX_W'(NUM_DIGITS - 1);
        nz_q  <= 1'b0;
      end else if (state_q == ST_SCAN) begin
        shadow_q[7*int'(idx_q) +: 7] <= seg;
        idx_q <= idx_q - 1'b1;
        nz_q  <= nz_q | (nib != 4'd0);
      end
    end
  end

`ifdef HEX_BLINK_EN
  localparam int DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [DIV_W-1:0] div_q;
  logic             phase_q, phase_d;
  logic [HEX_W-1:0] hex_out_q;

  assign phase_d = (div_q == DIV_W'(BLINK_DIV - 1)) ? ~phase_q : phase_q;

  // Free-running blink divider; phase_q = 1 means displays on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      div_q   <= (div_q == DIV_W'(BLINK_DIV - 1)) ? '0 : div_q + 1'b1;
      phase_q <= phase_d;
    end
  end

  // Output register applies the blink mask on top of the stored value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hex_out_q <= '1;
    else     hex_out_q <= (blink && !phase_d) ? '1 : hex_store_d;
  end

  assign HEX = hex_out_q;
`else
  assign HEX = hex_store_q;
`endif

endmodule
